multicycle_ctrl: RTL

//  Multi-cycle instruction sequencer: initiator side of the register file interface.
//  - Accepts one instruction, then decodes it.
//  - Drives the read addresses and consumes the read data.
//  - Computes the result and drives the write port.

---
 rtl/ctrl_pkg.sv | 21 ++
 rtl/imm_gen.sv | 33 +++
 rtl/multicycle_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle_ctrl instruction sequencer:
// FSM state encoding and the RV32I opcode/funct fields it recognises.
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC,
    WB
  } state_t;

  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extends the I-type or B-type immediate of an
// RV32I instruction, chosen by opcode. Opcodes without an immediate give 0.
// Ports:
//   instr  in   32          instruction word
//   imm    out  DATA_WIDTH  sign-extended immediate
module imm_gen
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           instr,
  output logic [DATA_WIDTH-1:0] imm
);

  logic signed [11:0] i_imm;
  logic signed [12:0] b_imm;

  // rs1/funct3 bits never carry immediate data for I/B formats
  logic unused_bits;
  assign unused_bits = ^instr[19:12];

  always_comb begin
    i_imm = instr[31:20];
    b_imm = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm   = '0;
    case (instr[6:0])
      OP_ADDI:   imm = {{(DATA_WIDTH-12){i_imm[11]}}, i_imm};
      OP_BRANCH: imm = {{(DATA_WIDTH-13){b_imm[12]}}, b_imm};
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer (initiator side of the register file).
// Accepts one instruction in IDLE, then walks DECODE -> EXEC -> WB.
// Executes ADDI and BNE; any other encoding pulses illegal in DECODE.
// Optional feature: define RTYPE_ADD_EN to also execute R-type ADD.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   instr_valid/instr     instruction handshake in; instr_ready out (IDLE)
//   AD1/AD2/AD3           rs1/rs2/rd register addresses (DECODE..WB)
//   RD1/RD2               combinational register file read data
//   WE3/WD3               register file write port (WB only)
//   pc_src/imm_out        branch outcome and immediate for the PC logic
//   done/illegal          one-cycle retire / drop pulses
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  input  logic [31:0]           instr,
  output logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] AD1,
  output logic [ADDR_WIDTH-1:0] AD2,
  output logic [ADDR_WIDTH-1:0] AD3,
  output logic                  WE3,
  output logic [DATA_WIDTH-1:0] WD3,
  input  logic [DATA_WIDTH-1:0] RD1,
  input  logic [DATA_WIDTH-1:0] RD2,
  output logic                  pc_src,
  output logic [DATA_WIDTH-1:0] imm_out,
  output logic                  done,
  output logic                  illegal
);

  state_t                state, state_nxt;
  logic [31:0]           instr_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  taken_q;
  logic [DATA_WIDTH-1:0] imm;

  logic op_addi, op_bne, op_add, op_write, op_legal;

  imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
    .instr (instr_q),
    .imm   (imm)
  );

  always_comb begin
    op_addi = (instr_q[6:0] == OP_ADDI) && (instr_q[14:12] == F3_ADD);
    op_bne  = (instr_q[6:0] == OP_BRANCH) && (instr_q[14:12] == F3_BNE);
`ifdef RTYPE_ADD_EN
    op_add  = (instr_q[6:0] == OP_RTYPE) && (instr_q[14:12] == F3_ADD) &&
              (instr_q[31:25] == F7_ADD);
`else
    op_add  = 1'b0;
`endif
    op_write = op_addi || op_add;
    op_legal = op_write || op_bne;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      instr_q  <= '0;
      result_q <= '0;
      taken_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && instr_valid) begin
        instr_q <= instr;
      end
      // RD1/RD2 are valid here because the addresses were driven in DECODE
      if (state == EXEC) begin
        result_q <= op_add ? (RD1 + RD2) : (RD1 + imm);
        taken_q  <= (RD1 != RD2);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    AD1         = '0;
    AD2         = '0;
    AD3         = '0;
    WE3         = 1'b0;
    WD3         = '0;
    pc_src      = 1'b0;
    imm_out     = '0;
    done        = 1'b0;
    illegal     = 1'b0;

    if (state != IDLE) begin
      AD1     = ADDR_WIDTH'(instr_q[19:15]);
      AD2     = ADDR_WIDTH'(instr_q[24:20]);
      AD3     = ADDR_WIDTH'(instr_q[11:7]);
      imm_out = imm;
    end

    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = DECODE;
      end
      DECODE: begin
        if (op_legal) begin
          state_nxt = EXEC;
        end else begin
          illegal   = 1'b1;
          state_nxt = IDLE;
        end
      end
      EXEC: state_nxt = WB;
      WB: begin
        done      = 1'b1;
        WD3       = result_q;
        WE3       = op_write && (instr_q[11:7] != 5'd0);
        pc_src    = op_bne && taken_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
